// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use check against EX plus a per-register scoreboard
// of outstanding long-latency writes retired through NUM_WB writeback ports.
module hazard_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_WB    = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int PERF_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rs1,
  input  logic [ADDR_W-1:0]        issue_rs2,
  input  logic                     issue_rs1_used,
  input  logic                     issue_rs2_used,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic                     issue_long,
  input  logic                     flush,
  input  logic                     ex_mem_read,
  input  logic [ADDR_W-1:0]        ex_rd,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ADDR_W-1:0] wb_rd,
  output logic                     stall,
  output logic [1:0]               stall_reason,
  output logic                     busy,
  output logic                     err_underflow,
  output logic [PERF_W-1:0]        stall_cycles
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int HIT_W = $clog2(NUM_WB + 1);
  localparam int SUM_W = CNT_W + $clog2(NUM_WB) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt [1:REG_COUNT-1];
  logic              r_err_underflow;
  logic [PERF_W-1:0] r_stall_cycles;

  // Address-space-wide views so any encodable address can be looked up safely.
  logic [CNT_W-1:0]  w_cnt_ext [NREG];
  logic [HIT_W-1:0]  w_hits    [NREG];
  logic [NREG-1:0]   w_uf;

  logic w_active, w_load_use, w_raw1, w_raw2, w_raw, w_waw, w_stall, w_alloc;
  logic w_byp1, w_byp2, w_busy;

  assign w_active = issue_valid && !flush && !rst;

  assign w_load_use = w_active && ex_mem_read && (ex_rd != '0) &&
                      ((issue_rs1_used && (issue_rs1 == ex_rd)) ||
                       (issue_rs2_used && (issue_rs2 == ex_rd)));

  assign w_byp1 = (WB_BYPASS != 0) &&
                  (SUM_W'(w_cnt_ext[issue_rs1]) == SUM_W'(w_hits[issue_rs1]));
  assign w_byp2 = (WB_BYPASS != 0) &&
                  (SUM_W'(w_cnt_ext[issue_rs2]) == SUM_W'(w_hits[issue_rs2]));

  assign w_raw1 = issue_rs1_used && (issue_rs1 != '0) && (w_cnt_ext[issue_rs1] != '0) && !w_byp1;
  assign w_raw2 = issue_rs2_used && (issue_rs2 != '0) && (w_cnt_ext[issue_rs2] != '0) && !w_byp2;
  assign w_raw  = w_active && (w_raw1 || w_raw2);

  // Saturation is judged on the current count, ignoring same-cycle retirements.
  assign w_waw = w_active && issue_long && (issue_rd != '0) && (w_cnt_ext[issue_rd] == CNT_MAX);

  assign w_stall = w_load_use || w_raw || w_waw;
  assign w_alloc = w_active && !w_stall && issue_long && (issue_rd != '0);

  always_comb begin
    stall_reason = 2'b00;
    if (w_load_use)  stall_reason = 2'b01;
    else if (w_raw)  stall_reason = 2'b10;
    else if (w_waw)  stall_reason = 2'b11;
  end

  assign stall = w_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_slot
      always_comb begin
        w_hits[gi] = '0;
        for (int p = 0; p < NUM_WB; p++) begin
          if ((gi != 0) && wb_valid[p] && (wb_rd[p*ADDR_W +: ADDR_W] == ADDR_W'(gi)))
            w_hits[gi] = w_hits[gi] + HIT_W'(1);
        end
      end

      if ((gi >= 1) && (gi < REG_COUNT)) begin : g_reg
        logic             w_inc;
        logic [SUM_W-1:0] w_sum;

        assign w_inc = w_alloc && (issue_rd == ADDR_W'(gi));
        // Sign bit of the widened sum flags more retirements than outstanding writes.
        assign w_sum = SUM_W'(r_cnt[gi]) + SUM_W'(w_inc) - SUM_W'(w_hits[gi]);
        assign w_uf[gi]      = w_sum[SUM_W-1];
        assign w_cnt_ext[gi] = r_cnt[gi];

        always_ff @(posedge clk) begin
          if (rst)
            r_cnt[gi] <= '0;
          else if (w_sum[SUM_W-1])
            r_cnt[gi] <= '0;
          else
            r_cnt[gi] <= w_sum[CNT_W-1:0];
        end
      end else begin : g_none
        assign w_uf[gi]      = 1'b0;
        assign w_cnt_ext[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    w_busy = 1'b0;
    for (int r = 1; r < REG_COUNT; r++)
      w_busy = w_busy | (r_cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_underflow <= 1'b0;
      r_stall_cycles  <= '0;
    end else begin
      r_err_underflow <= r_err_underflow | (|w_uf);
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign busy          = w_busy;
  assign err_underflow = r_err_underflow;
  assign stall_cycles  = r_stall_cycles;

endmodule
